vga_fb_arbiter: RTL and testbench

Owns the single-port pixel framebuffer memory behind the 800x600 VGA output: it shares that memory between the scanout reader, which feeds the VGA timing/colour path and has strict priority, and a pixel writer (drawing engine or host). It double-buffers the framebuffer, always reading the front bank and writing the back bank. Bank swaps are deferred to the vertical-blanking boundary so a frame is never torn. It sits between the VGA timing generator and the memory controller, in the MAX10_CLK1_50 domain.

---
 rtl/vga_fb_arbiter.sv | 153 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Double-buffered framebuffer arbiter: strict-priority scanout reads, FIFO-buffered pixel
// writes to the back bank, and a bank swap held off until vertical blanking.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESET_N,
  input  logic              frame_start,
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic [DATA_W-1:0] sc_rdata,
  output logic              sc_rvalid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_bank,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_ACK,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_active;
  logic              r_front;
  logic              r_frame_seen;
  logic              w_frame_seen_nxt;
  logic              w_toggle;
  logic              w_front_nxt;

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  logic [RD_LAT:0]   r_rd_vld;

  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  // r_active keeps the writer stalled until the first edge after reset release.
  assign wr_ready   = r_active && !w_full && (r_state != S_PENDING);
  assign w_push     = wr_valid && wr_ready;
  assign w_pop      = !sc_req && !w_empty;
  assign swap_ack   = (r_state == S_ACK);
  assign front_bank = r_front;
  assign w_front_nxt = r_front ^ w_toggle;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_frame_seen_nxt = r_frame_seen;
    w_toggle         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (swap_req) begin
          w_state_nxt      = S_PENDING;
          w_frame_seen_nxt = 1'b0;
        end
      end
      S_PENDING: begin
        if (frame_start) w_frame_seen_nxt = 1'b1;
        if ((r_frame_seen || frame_start) && w_empty && !w_pop) begin
          w_toggle    = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:   w_state_nxt = S_HOLD;
      S_HOLD:  if (!swap_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: FIFO storage has no reset; only the pointers and count define its contents, so clearing the array buys nothing.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values and ordering does not matter.
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_active     <= 1'b0;
      r_state      <= S_IDLE;
      r_front      <= 1'b0;
      r_frame_seen <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rd_vld     <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      sc_rvalid    <= 1'b0;
      sc_rdata     <= '0;
    end else begin
      r_active     <= 1'b1;
      r_state      <= w_state_nxt;
      r_front      <= w_front_nxt;
      r_frame_seen <= w_frame_seen_nxt;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      // A read on the toggle edge already targets the new front bank.
      if (sc_req) begin
        mem_addr <= {w_front_nxt, sc_addr};
        mem_we   <= 1'b0;
      end else if (w_pop) begin
        mem_addr  <= {~r_front, r_fifo_addr[r_rd_ptr]};
        mem_wdata <= r_fifo_data[r_rd_ptr];
        mem_we    <= 1'b1;
      end else begin
        mem_we <= 1'b0;
      end

      r_rd_vld  <= {r_rd_vld[RD_LAT-1:0], sc_req};
      sc_rvalid <= r_rd_vld[RD_LAT];
      if (r_rd_vld[RD_LAT]) sc_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a latency-accurate memory model plus expected-read and
// expected-write queues, exercised by one task per scenario.
module tb_vga_fb_arbiter;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 12;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              sc_req = 1'b0;
  logic [ADDR_W-1:0] sc_addr = '0;
  logic [DATA_W-1:0] sc_rdata;
  logic              sc_rvalid;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              swap_req = 1'b0;
  logic              swap_ack;
  logic              front_bank;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N      (rst_n),
    .frame_start  (frame_start),
    .sc_req       (sc_req),
    .sc_addr      (sc_addr),
    .sc_rdata     (sc_rdata),
    .sc_rvalid    (sc_rvalid),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .front_bank   (front_bank),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_exp_t;

  typedef struct {
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  rd_exp_t rq[$];
  wr_exp_t wq[$];
  rd_exp_t re;
  wr_exp_t we;
  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc     = 0;
  int      n_rv    = 0;
  int      n_we    = 0;

  // Memory model: pixel value is the low address bits with the bank folded into the top bit.
  function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W:0] a);
    return a[DATA_W-1:0] ^ {a[ADDR_W], {(DATA_W-1){1'b0}}};
  endfunction

  logic [ADDR_W:0] mem_pipe [RD_LAT-1];
  always @(posedge clk) begin
    mem_pipe[0] <= mem_addr;
    for (int i = 1; i < RD_LAT - 1; i++) mem_pipe[i] <= mem_pipe[i-1];
    mem_rdata <= model_data(mem_pipe[RD_LAT-2]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sc_rvalid) begin
      n_rv++;
      n_tests++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got sc_rdata=%h at cyc %0d, expected no read outstanding", sc_rdata, cyc);
      end else begin
        re = rq.pop_front();
        if (sc_rdata !== re.data || cyc != re.due) begin
          n_fail++;
          $display("FAIL rd_data: got %h at cyc %0d, expected %h at cyc %0d", sc_rdata, cyc, re.data, re.due);
        end
      end
    end
    if (mem_we) begin
      n_we++;
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got mem_addr=%h data=%h, expected no write pending", mem_addr, mem_wdata);
      end else begin
        we = wq.pop_front();
        if (mem_addr !== we.addr || mem_wdata !== we.data) begin
          n_fail++;
          $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h", mem_addr, mem_wdata, we.addr, we.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rq.size() != 0 || wq.size() != 0); i++) tick();
  endtask

  task automatic issue_rd(input int a, input logic bank);
    sc_req  = 1'b1;
    sc_addr = ADDR_W'(a);
    rq.push_back('{model_data({bank, ADDR_W'(a)}), cyc + RD_LAT + 2});
  endtask

  task automatic offer_wr(input int a, input int d, input logic bank, output logic acc);
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(a);
    wr_data  = DATA_W'(d);
    acc      = wr_ready;
    if (acc) wq.push_back('{{bank, ADDR_W'(a)}, DATA_W'(d)});
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({sc_rvalid, sc_rdata, wr_ready, swap_ack, front_bank} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got rvalid=%b rdata=%h ready=%b ack=%b front=%b, expected all 0",
               sc_rvalid, sc_rdata, wr_ready, swap_ack, front_bank);
    end
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got we=%b addr=%h wdata=%h, expected all 0", mem_we, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (wr_ready !== 1'b1 || front_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b front=%b, expected ready=1 front=0", wr_ready, front_bank);
    end
  endtask

  task automatic test_read_latency();
    int rv0;
    rv0 = n_rv;
    for (int i = 0; i < 800; i++) begin
      tick();
      issue_rd(i, 1'b0);
    end
    tick();
    sc_req = 1'b0;
    drain();
    n_tests++;
    if (n_rv - rv0 != 800 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL read_count: got %0d pulses (%0d left), expected 800 (0 left)", n_rv - rv0, rq.size());
    end
  endtask

  task automatic test_write_latency();
    logic            acc;
    logic [ADDR_W:0] exp_addr;
    exp_addr = {1'b1, ADDR_W'(5)};
    tick();
    offer_wr(5, 'hA5A, 1'b1, acc);
    @(negedge clk);
    n_tests++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL wlat_accept: got ready=%b, expected 1", acc);
    end
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wlat_early: got mem_we=%b, expected 0", mem_we);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL wlat_issue: got we=%b addr=%h, expected we=1 addr=%h", mem_we, mem_addr, exp_addr);
    end
    drain();
  endtask

  task automatic test_priority();
    logic acc;
    for (int i = 0; i < 5; i++) begin
      tick();
      issue_rd(20 + i, 1'b0);
      offer_wr(100 + i, 'h100 + i, 1'b1, acc);
      @(negedge clk);
      n_tests++;
      if (acc !== (i < 4) || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL prio_fill[%0d]: got ready=%b we=%b, expected ready=%b we=0", i, acc, mem_we, i < 4);
      end
    end
    tick();
    issue_rd(25, 1'b0);
    wr_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_full: got ready=%b we=%b, expected ready=0 we=0", wr_ready, mem_we);
    end
    tick();
    sc_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if (mem_we !== 1'b1 || wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL prio_drain[%0d]: got we=%b ready=%b, expected we=1 ready=1", j, mem_we, wr_ready);
      end
    end
    drain();
    n_tests++;
    if (rq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL prio_left: got %0d reads %0d writes outstanding, expected 0", rq.size(), wq.size());
    end
  endtask

  task automatic test_swap_load();
    logic acc;
    for (int i = 0; i < 4; i++) begin
      tick();
      issue_rd(200 + i, 1'b0);
      offer_wr(300 + i, 'h300 + i, 1'b1, acc);
      @(negedge clk);
      n_tests++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL load_fill[%0d]: got ready=%b, expected 1", i, acc);
      end
    end
    tick();
    issue_rd(204, 1'b0);
    wr_valid = 1'b0;
    swap_req = 1'b1;
    tick();
    issue_rd(205, 1'b0);
    frame_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      frame_start = 1'b0;
      issue_rd(206 + i, 1'b0);
      @(negedge clk);
      n_tests++;
      if (front_bank !== 1'b0 || swap_ack !== 1'b0 || wr_ready !== 1'b0 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL load_wait[%0d]: got front=%b ack=%b ready=%b we=%b, expected all 0",
                 i, front_bank, swap_ack, wr_ready, mem_we);
      end
    end
    tick();
    sc_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if (mem_we !== 1'b1 || front_bank !== 1'b0 || wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL load_drain[%0d]: got we=%b front=%b ready=%b, expected we=1 front=0 ready=0",
                 j, mem_we, front_bank, wr_ready);
      end
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (front_bank !== 1'b1 || swap_ack !== 1'b1 || mem_we !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_toggle: got front=%b ack=%b we=%b ready=%b, expected front=1 ack=1 we=0 ready=1",
               front_bank, swap_ack, mem_we, wr_ready);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ack_len: got ack=%b, expected 0", swap_ack);
    end
    swap_req = 1'b0;
    tick();
    drain();
    n_tests++;
    if (rq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL load_left: got %0d reads %0d writes outstanding, expected 0", rq.size(), wq.size());
    end
  endtask

  task automatic test_reset_mid_read();
    logic acc;
    int   rv0;
    int   we0;
    tick();
    issue_rd(30, 1'b1);
    offer_wr(700, 'h700, 1'b0, acc);
    tick();
    issue_rd(31, 1'b1);
    wr_valid = 1'b0;
    tick();
    issue_rd(32, 1'b1);
    tick();
    sc_req = 1'b0;
    rst_n  = 1'b0;
    rq.delete();
    wq.delete();
    rv0 = n_rv;
    we0 = n_we;
    @(negedge clk);
    n_tests++;
    if (front_bank !== 1'b0 || sc_rvalid !== 1'b0 || wr_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_hold: got front=%b rvalid=%b ready=%b we=%b, expected all 0",
               front_bank, sc_rvalid, wr_ready, mem_we);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (wr_ready !== 1'b1 || front_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: got ready=%b front=%b, expected ready=1 front=0", wr_ready, front_bank);
    end
    repeat (10) tick();
    n_tests++;
    if (n_rv != rv0 || n_we != we0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: got %0d rvalid %0d writes after reset, expected 0 and 0", n_rv - rv0, n_we - we0);
    end
  endtask

  task automatic test_swap_empty();
    logic acc;
    tick();
    sc_req      = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    swap_req    = 1'b1;
    offer_wr(400, 'h4AA, 1'b1, acc);
    @(negedge clk);
    n_tests++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_same_cycle_wr: got ready=%b, expected 1", acc);
    end
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_pending_ready: got ready=%b, expected 0", wr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if (front_bank !== 1'b0 || swap_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL swap_ignore_fs[%0d]: got front=%b ack=%b, expected front=0 ack=0", i, front_bank, swap_ack);
      end
    end
    tick();
    issue_rd(10, 1'b0);
    tick();
    issue_rd(11, 1'b1);
    frame_start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (front_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_early: got front=%b, expected 0", front_bank);
    end
    tick();
    frame_start = 1'b0;
    issue_rd(12, 1'b1);
    @(negedge clk);
    n_tests++;
    if (front_bank !== 1'b1 || swap_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_toggle: got front=%b ack=%b, expected front=1 ack=1", front_bank, swap_ack);
    end
    tick();
    issue_rd(13, 1'b1);
    offer_wr(500, 'h5BB, 1'b0, acc);
    @(negedge clk);
    n_tests++;
    if (swap_ack !== 1'b0 || acc !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_hold: got ack=%b ready=%b, expected ack=0 ready=1", swap_ack, acc);
    end
    tick();
    sc_req      = 1'b0;
    wr_valid    = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    swap_req    = 1'b0;
    @(negedge clk);
    n_tests++;
    if (front_bank !== 1'b1 || swap_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_hold_fs: got front=%b ack=%b, expected front=1 ack=0", front_bank, swap_ack);
    end
    drain();
    n_tests++;
    if (rq.size() != 0 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL swap_left: got %0d reads %0d writes outstanding, expected 0", rq.size(), wq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   we0;
    we0 = n_we;
    for (int i = 0; i < 8; i++) begin
      tick();
      offer_wr(600 + i, 'h600 + i, 1'b0, acc);
      @(negedge clk);
      n_tests++;
      if (acc !== 1'b1 || (i >= 2 && mem_we !== 1'b1)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got ready=%b we=%b, expected ready=1 we=%b", i, acc, mem_we, i >= 2);
      end
    end
    tick();
    wr_valid = 1'b0;
    drain();
    repeat (2) tick();
    n_tests++;
    if (n_we - we0 != 8 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d writes (%0d left), expected 8 (0 left)", n_we - we0, wq.size());
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_latency();
    test_write_latency();
    test_priority();
    test_swap_load();
    test_reset_mid_read();
    test_swap_empty();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
